spmd_finish_monitor: RTL and testbench

- Sits directly downstream of the SPMD loader/io complex in the manycore testbench.
- Consumes the loader's print-stat stream plus finish/fail packet strobes, and pairs kernel start/end stat tags into cycle counts.
- Runs an inactivity watchdog and produces a single registered end-of-simulation verdict (pass/fail/timeout) for the testbench to act on.

---
 rtl/spmd_finish_monitor.sv | 180 ++++++++++++++++++
 tb/tb_spmd_finish_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spmd_finish_monitor.sv
// spmd_finish_monitor
//   End-of-simulation monitor placed downstream of the SPMD loader/io complex.
//   Counts finish packets, reacts to fail packets, pairs kernel start/end
//   print-stat tags into cycle counts, and runs an inactivity watchdog. The
//   final verdict (pass/fail/timeout) is registered and sticky until reset.
//
//   Optional build macro: SPMD_FINISH_MONITOR_DISPLAY_EN
//     When defined, simulation-only $display messages report each completed
//     kernel and the verdict. When undefined no display code is compiled.
//
// Ports:
//   clk_i             core clock
//   reset_n_i         asynchronous active-low reset
//   enable_i          monitoring enable; low while in RUN freezes everything
//   print_stat_v_i    print-stat tag strobe
//   print_stat_tag_i  tag: [top:top-1] kind (0 start, 1 end, 2/3 generic), low bits id
//   finish_v_i        one finish packet received
//   fail_v_i          fail packet received
//   done_o            verdict reached (sticky)
//   pass_o            verdict is pass
//   timeout_o         verdict is watchdog timeout
//   finish_count_o    finish packets seen (saturating)
//   active_mask_o     kernels started but not yet ended
//   kernel_done_v_o   one-cycle pulse on a matched end tag
//   kernel_id_o       id of the matched kernel
//   kernel_cycles_o   duration of the matched kernel
//   error_o           sticky protocol error
module spmd_finish_monitor #(
  parameter int unsigned data_width_p       = 32,
  parameter int unsigned num_finish_p       = 1,
  parameter int unsigned finish_ctr_width_p = 8,
  parameter int unsigned num_kernel_ids_p   = 16,
  parameter int unsigned cycle_width_p      = 32,
  parameter int unsigned timeout_cycles_p   = 1000000
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  input  logic                          print_stat_v_i,
  input  logic [data_width_p-1:0]       print_stat_tag_i,
  input  logic                          finish_v_i,
  input  logic                          fail_v_i,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          timeout_o,
  output logic [finish_ctr_width_p-1:0] finish_count_o,
  output logic [num_kernel_ids_p-1:0]   active_mask_o,
  output logic                          kernel_done_v_o,
  output logic [3:0]                    kernel_id_o,
  output logic [cycle_width_p-1:0]      kernel_cycles_o,
  output logic                          error_o
);

  localparam int unsigned IdW = (num_kernel_ids_p > 1) ? $clog2(num_kernel_ids_p) : 1;
  localparam logic [cycle_width_p-1:0]      WdLast       = cycle_width_p'(timeout_cycles_p - 1);
  localparam logic [finish_ctr_width_p-1:0] FinishTarget = finish_ctr_width_p'(num_finish_p);
  localparam logic [finish_ctr_width_p-1:0] FinishMax    = '1;

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTimeout} state_e;

  state_e                          state;
  logic [cycle_width_p-1:0]        cycle_cnt;
  logic [cycle_width_p-1:0]        wdog;
  logic [cycle_width_p-1:0]        start_time [num_kernel_ids_p];

  logic [1:0]                      tag_kind;
  logic [IdW-1:0]                  tag_id;
  logic                            tag_start;
  logic                            tag_end;
  logic                            any_event;
  logic [finish_ctr_width_p-1:0]   finish_next;
  logic                            finish_hit;
  logic                            wdog_hit;
  logic                            unused_tag_bits;

  // Ids beyond the tracked range alias onto the low id bits.
  assign unused_tag_bits = ^print_stat_tag_i[data_width_p-3:IdW];

  always_comb begin
    tag_kind    = print_stat_tag_i[data_width_p-1 -: 2];
    tag_id      = print_stat_tag_i[IdW-1:0];
    tag_start   = print_stat_v_i && (tag_kind == 2'd0);
    tag_end     = print_stat_v_i && (tag_kind == 2'd1);
    any_event   = print_stat_v_i || finish_v_i || fail_v_i;
    finish_next = (finish_count_o == FinishMax) ? FinishMax
                                                : finish_count_o + finish_ctr_width_p'(1);
    finish_hit  = finish_v_i && (finish_next == FinishTarget);
    // A zero timeout disables the watchdog entirely.
    wdog_hit    = (timeout_cycles_p != 0) && !any_event && (wdog == WdLast);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= StIdle;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      finish_count_o  <= '0;
      active_mask_o   <= '0;
      kernel_done_v_o <= 1'b0;
      kernel_id_o     <= '0;
      kernel_cycles_o <= '0;
      error_o         <= 1'b0;
      cycle_cnt       <= '0;
      wdog            <= '0;
      for (int i = 0; i < int'(num_kernel_ids_p); i++) begin
        start_time[i] <= '0;
      end
    end else begin
      kernel_done_v_o <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable_i) state <= StRun;
        end
        StRun: begin
          if (enable_i) begin
            cycle_cnt <= cycle_cnt + cycle_width_p'(1);
            wdog      <= any_event ? '0 : wdog + cycle_width_p'(1);
            if (finish_v_i) finish_count_o <= finish_next;

            if (tag_start) begin
              // Restarting an active kernel is flagged but the new start wins.
              if (active_mask_o[tag_id]) error_o <= 1'b1;
              active_mask_o[tag_id] <= 1'b1;
              start_time[tag_id]    <= cycle_cnt;
            end

            if (tag_end) begin
              if (active_mask_o[tag_id]) begin
                active_mask_o[tag_id] <= 1'b0;
                kernel_done_v_o       <= 1'b1;
                kernel_id_o           <= 4'(tag_id);
                // Modulo subtraction tolerates one wrap of the cycle counter.
                kernel_cycles_o       <= cycle_cnt - start_time[tag_id];
              end else begin
                error_o <= 1'b1;
              end
            end

            if (fail_v_i) begin
              state  <= StFail;
              done_o <= 1'b1;
            end else if (finish_hit) begin
              state  <= StPass;
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end else if (wdog_hit) begin
              state     <= StTimeout;
              done_o    <= 1'b1;
              timeout_o <= 1'b1;
            end
          end
        end
        default: ;  // terminal verdict states hold until reset
      endcase
    end
  end

`ifdef SPMD_FINISH_MONITOR_DISPLAY_EN
  logic done_prev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) done_prev <= 1'b0;
    else            done_prev <= done_o;
  end

  always @(posedge clk_i) begin
    if (kernel_done_v_o) begin
      $display("[INFO][FINISH-MONITOR] kernel %0d cycles %0d", kernel_id_o, kernel_cycles_o);
    end
    if (done_o && !done_prev) begin
      $display("[INFO][FINISH-MONITOR] %s at cycle %0d finish count %0d",
               pass_o ? "PASS" : (timeout_o ? "TIMEOUT" : "FAIL"), cycle_cnt, finish_count_o);
    end
  end
`else
  // Display messages disabled; behaviour is identical.
`endif

endmodule

// File: tb/tb_spmd_finish_monitor.sv
module tb_spmd_finish_monitor;

  localparam int unsigned NumFinish = 4;
  localparam int unsigned Timeout   = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        psv = 1'b0;
  logic [31:0] tag = '0;
  logic        finish_v = 1'b0;
  logic        fail_v = 1'b0;
  logic        done, pass, timeout, kdv, err;
  logic [7:0]  fcount;
  logic [15:0] mask;
  logic [3:0]  kid;
  logic [31:0] kcyc;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  always #5 clk = ~clk;

  spmd_finish_monitor #(
    .data_width_p      (32),
    .num_finish_p      (NumFinish),
    .finish_ctr_width_p(8),
    .num_kernel_ids_p  (16),
    .cycle_width_p     (32),
    .timeout_cycles_p  (Timeout)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .enable_i        (enable),
    .print_stat_v_i  (psv),
    .print_stat_tag_i(tag),
    .finish_v_i      (finish_v),
    .fail_v_i        (fail_v),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (timeout),
    .finish_count_o  (fcount),
    .active_mask_o   (mask),
    .kernel_done_v_o (kdv),
    .kernel_id_o     (kid),
    .kernel_cycles_o (kcyc),
    .error_o         (err)
  );

  function automatic logic [31:0] mk_tag(input logic [1:0] kind, input logic [3:0] id);
    return {kind, 26'd0, id};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance n falling edges; inputs change and outputs are sampled there.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask

  // Advance to falling edge n, sending a generic tag every 30 cycles as keepalive.
  task automatic run_to(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
      psv = (t % 30 == 0);
      tag = mk_tag(2'd2, 4'd0);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    psv      = 1'b0;
    finish_v = 1'b0;
    fail_v   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    t = 0;
  endtask

  task automatic pulse_finish();
    finish_v = 1'b1;
    cyc(1);
    finish_v = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_done"},    64'(done),    64'd0);
    chk({pfx, "_pass"},    64'(pass),    64'd0);
    chk({pfx, "_timeout"}, 64'(timeout), 64'd0);
    chk({pfx, "_fcount"},  64'(fcount),  64'd0);
    chk({pfx, "_mask"},    64'(mask),    64'd0);
    chk({pfx, "_kdv"},     64'(kdv),     64'd0);
    chk({pfx, "_kid"},     64'(kid),     64'd0);
    chk({pfx, "_kcyc"},    64'(kcyc),    64'd0);
    chk({pfx, "_err"},     64'(err),     64'd0);
  endtask

  initial begin
    // Reset state, then IDLE must not run the watchdog without enable.
    do_reset();
    chk_all_zero("rst");
    cyc(100);
    chk("idle_no_timeout", 64'(done), 64'd0);

    // Watchdog: timeout lands exactly 50 cycles after entering RUN.
    enable = 1'b1;
    cyc(50);
    chk("wd_before_done", 64'(done), 64'd0);
    cyc(1);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_done",    64'(done),    64'd1);
    chk("wd_pass",    64'(pass),    64'd0);

    // Watchdog restart: an event on the would-be timeout cycle clears the count.
    do_reset();
    enable = 1'b1;
    cyc(50);
    psv = 1'b1;
    tag = mk_tag(2'd3, 4'd0);
    cyc(1);
    psv = 1'b0;
    chk("wdr_no_timeout", 64'(done), 64'd0);
    chk("wdr_mask",       64'(mask), 64'd0);
    cyc(49);
    chk("wdr_before", 64'(done), 64'd0);
    cyc(1);
    chk("wdr_timeout", 64'(timeout), 64'd1);

    // Finish counting with an enable-low freeze in the middle.
    do_reset();
    enable = 1'b1;
    cyc(10);
    pulse_finish();
    chk("fin_cnt1", 64'(fcount), 64'd1);
    cyc(9);
    pulse_finish();
    chk("fin_cnt2", 64'(fcount), 64'd2);
    enable = 1'b0;
    cyc(80);
    pulse_finish();
    chk("freeze_cnt",  64'(fcount), 64'd2);
    chk("freeze_done", 64'(done),   64'd0);
    enable = 1'b1;
    cyc(9);
    pulse_finish();
    chk("fin_cnt3",  64'(fcount), 64'd3);
    chk("fin_done3", 64'(done),   64'd0);
    cyc(9);
    pulse_finish();
    chk("fin_cnt4", 64'(fcount), 64'd4);
    chk("fin_done", 64'(done),   64'd1);
    chk("fin_pass", 64'(pass),   64'd1);
    cyc(9);
    pulse_finish();
    chk("fin_cnt5",     64'(fcount),  64'd4);
    chk("fin_pass5",    64'(pass),    64'd1);
    chk("fin_timeout5", 64'(timeout), 64'd0);

    // Fail wins over the completing finish in the same cycle.
    do_reset();
    enable = 1'b1;
    cyc(5);
    repeat (3) begin
      pulse_finish();
      cyc(4);
    end
    finish_v = 1'b1;
    fail_v   = 1'b1;
    cyc(1);
    finish_v = 1'b0;
    fail_v   = 1'b0;
    chk("fp_done",    64'(done),    64'd1);
    chk("fp_pass",    64'(pass),    64'd0);
    chk("fp_timeout", 64'(timeout), 64'd0);

    // Kernel pairing: start id 3 at RUN cycle 100, end at RUN cycle 350.
    do_reset();
    enable = 1'b1;
    run_to(101);
    psv = 1'b1;
    tag = mk_tag(2'd0, 4'd3);
    run_to(102);
    chk("kp_mask_set", 64'(mask), 64'h0008);
    chk("kp_kdv_idle", 64'(kdv),  64'd0);
    run_to(351);
    psv = 1'b1;
    tag = mk_tag(2'd1, 4'd3);
    run_to(352);
    chk("kp_kdv",      64'(kdv),  64'd1);
    chk("kp_kid",      64'(kid),  64'd3);
    chk("kp_kcyc",     64'(kcyc), 64'd250);
    chk("kp_mask_clr", 64'(mask), 64'd0);
    chk("kp_err",      64'(err),  64'd0);
    run_to(353);
    chk("kp_kdv_once",  64'(kdv),  64'd0);
    chk("kp_kid_hold",  64'(kid),  64'd3);
    chk("kp_kcyc_hold", 64'(kcyc), 64'd250);

    // Protocol error: end for id 5 that never started.
    run_to(355);
    psv = 1'b1;
    tag = mk_tag(2'd1, 4'd5);
    run_to(356);
    chk("pe_err",  64'(err),  64'd1);
    chk("pe_kdv",  64'(kdv),  64'd0);
    chk("pe_mask", 64'(mask), 64'd0);

    // Mid-run reset while kernel 2 is active: outputs clear without a clock edge.
    run_to(357);
    psv = 1'b1;
    tag = mk_tag(2'd0, 4'd2);
    run_to(358);
    chk("mr_mask_set", 64'(mask), 64'h0004);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mr");
    psv = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    finish_v = 1'b1;  // lands while still in IDLE, must be ignored
    t = 0;
    cyc(1);
    finish_v = 1'b0;
    chk("mr_idle_fin", 64'(fcount), 64'd0);
    psv = 1'b1;
    tag = mk_tag(2'd0, 4'd2);
    cyc(1);
    psv = 1'b0;
    cyc(4);
    psv = 1'b1;
    tag = mk_tag(2'd1, 4'd2);
    cyc(1);
    psv = 1'b0;
    chk("mr_kdv",  64'(kdv),  64'd1);
    chk("mr_kid",  64'(kid),  64'd2);
    chk("mr_kcyc", 64'(kcyc), 64'd5);
    pulse_finish();
    chk("mr_fcount", 64'(fcount), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
